// File: rtl/audio_dma_reader.sv
// audio_dma_reader
//   Streams packed 4-bit PCM samples from memory. A start trigger latches the
//   start address, block count, rate select and ROM bank. Each byte is then
//   fetched and played as two samples (high nibble first), each held for one
//   rate period counted in CPU ticks. When the byte count runs out, the block
//   returns to idle and raises a sticky interrupt.
//
// Ports
//   clk, reset_n       clock, asynchronous active-low reset
//   tick               CPU-rate enable; every rate period counts these only
//   dma_addr           start byte address (sampled at start trigger only)
//   dma_length         block count, bytes = length*16, 0 means 4096
//   dma_ctrl           [1:0] rate select, [6:4] ROM bank
//   trigger_wr/_data   trigger register write; data[7]=1 start, 0 stop
//   mem_req/addr/bank  memory read request, byte address, bank for 8000-BFFF
//   mem_ack/data       read completion with same-cycle data
//   sample/_valid      current 4-bit sample, one-cycle pulse on every update
//   busy               transfer active
//   irq/irq_ack        sticky end-of-transfer interrupt and its clear pulse
//   state_dbg          current FSM state (IDLE=0, FETCH=1, HI=2, LO=3)
module audio_dma_reader (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tick,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_length,
  input  logic [7:0]  dma_ctrl,
  input  logic        trigger_wr,
  input  logic [7:0]  trigger_data,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  output logic [2:0]  mem_bank,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  output logic [3:0]  sample,
  output logic        sample_valid,
  output logic        busy,
  output logic        irq,
  input  logic        irq_ack,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HI    = 2'd2,
    LO    = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] ptr_q, ptr_d;
  logic [12:0] cnt_q, cnt_d;
  logic [1:0]  rate_sel_q, rate_sel_d;
  logic [2:0]  bank_q, bank_d;
  logic [7:0]  data_q, data_d;
  logic [11:0] rate_cnt_q, rate_cnt_d;
  logic [3:0]  sample_q, sample_d;
  logic        sample_valid_q, sample_valid_d;
  logic        irq_q, irq_d;

  logic [11:0] period;
  logic        start, stop, expire, done;

  // Bits of the register inputs that carry no function here.
  logic unused_bits;
  assign unused_bits = ^{dma_ctrl[7], dma_ctrl[3:2], trigger_data[6:0]};

  always_comb begin
    case (rate_sel_q)
      2'd0:    period = 12'd256;
      2'd1:    period = 12'd512;
      2'd2:    period = 12'd1024;
      default: period = 12'd2048;
    endcase
  end

  assign start  = trigger_wr && trigger_data[7];
  assign stop   = trigger_wr && !trigger_data[7] && (state_q != IDLE);
  // The period ends on the tick that finds the counter at 1, so a load of N
  // gives exactly N ticks in the phase.
  assign expire = tick && (rate_cnt_q == 12'd1);

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    cnt_d          = cnt_q;
    rate_sel_d     = rate_sel_q;
    bank_d         = bank_q;
    data_d         = data_q;
    rate_cnt_d     = rate_cnt_q;
    sample_d       = sample_q;
    sample_valid_d = 1'b0;
    irq_d          = irq_q;
    done           = 1'b0;

    case (state_q)
      FETCH: begin
        if (mem_ack) begin
          data_d         = mem_data;
          sample_d       = mem_data[7:4];
          sample_valid_d = 1'b1;
          rate_cnt_d     = period;
          state_d        = HI;
        end
      end
      HI: begin
        if (expire) begin
          sample_d       = data_q[3:0];
          sample_valid_d = 1'b1;
          rate_cnt_d     = period;
          state_d        = LO;
        end else if (tick) begin
          rate_cnt_d = rate_cnt_q - 12'd1;
        end
      end
      LO: begin
        if (expire) begin
          cnt_d = cnt_q - 13'd1;
          ptr_d = ptr_q + 16'd1;
          if (cnt_q == 13'd1) begin
            state_d = IDLE;
            done    = 1'b1;
          end else begin
            state_d = FETCH;
          end
        end else if (tick) begin
          rate_cnt_d = rate_cnt_q - 12'd1;
        end
      end
      default: ;
    endcase

    // A completion outranks a coincident acknowledge. A stop leaves the
    // interrupt untouched, so a completion in the same cycle is dropped.
    if (irq_ack) irq_d = 1'b0;
    if (done && !stop) irq_d = 1'b1;

    // A start reloads everything from the registers regardless of state and
    // discards whatever the current transfer was doing this cycle; the
    // completion interrupt computed above still stands.
    if (start) begin
      ptr_d          = dma_addr;
      cnt_d          = {(dma_length == 8'd0), dma_length, 4'b0000};
      rate_sel_d     = dma_ctrl[1:0];
      bank_d         = dma_ctrl[6:4];
      rate_cnt_d     = 12'd0;
      sample_d       = sample_q;
      sample_valid_d = 1'b0;
      state_d        = FETCH;
    end else if (stop) begin
      sample_d       = sample_q;
      sample_valid_d = 1'b0;
      state_d        = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      ptr_q          <= 16'd0;
      cnt_q          <= 13'd0;
      rate_sel_q     <= 2'd0;
      bank_q         <= 3'd0;
      data_q         <= 8'd0;
      rate_cnt_q     <= 12'd0;
      sample_q       <= 4'd0;
      sample_valid_q <= 1'b0;
      irq_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      cnt_q          <= cnt_d;
      rate_sel_q     <= rate_sel_d;
      bank_q         <= bank_d;
      data_q         <= data_d;
      rate_cnt_q     <= rate_cnt_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      irq_q          <= irq_d;
    end
  end

  // Memory handshake: mem_req is the valid and mem_ack the ready. mem_req is
  // high in every FETCH cycle with mem_addr/mem_bank stable; the read
  // completes in the first cycle with both high, mem_data is taken in that
  // cycle, and mem_req is low from the next cycle. mem_ack alone is ignored.
  assign mem_req      = (state_q == FETCH);
  assign mem_addr     = ptr_q;
  assign mem_bank     = bank_q;
  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign busy         = (state_q != IDLE);
  assign irq          = irq_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_audio_dma_reader.sv
module tb_audio_dma_reader;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset_n;
  logic        tick;
  logic [15:0] dma_addr;
  logic [7:0]  dma_length;
  logic [7:0]  dma_ctrl;
  logic        trigger_wr;
  logic [7:0]  trigger_data;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [2:0]  mem_bank;
  logic        mem_ack;
  logic [7:0]  mem_data;
  logic [3:0]  sample;
  logic        sample_valid;
  logic        busy;
  logic        irq;
  logic        irq_ack;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  audio_dma_reader dut (
    .clk(clk), .reset_n(reset_n), .tick(tick),
    .dma_addr(dma_addr), .dma_length(dma_length), .dma_ctrl(dma_ctrl),
    .trigger_wr(trigger_wr), .trigger_data(trigger_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_bank(mem_bank),
    .mem_ack(mem_ack), .mem_data(mem_data),
    .sample(sample), .sample_valid(sample_valid), .busy(busy),
    .irq(irq), .irq_ack(irq_ack), .state_dbg(state_dbg)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- stimulus knobs ----------------
  bit tick_all  = 1'b0;   // tick every cycle (exact timing) vs random gaps
  bit data_rand = 1'b0;   // random read data vs byte index
  bit spur_en   = 1'b0;   // stray mem_ack while no request is pending
  int ack_min   = 1;
  int ack_max   = 1;
  logic [2:0] exp_bank = 3'd0;

  // ---------------- observation queues ----------------
  logic [15:0] rd_addr_q[$];
  logic [7:0]  rd_data_q[$];
  logic [3:0]  sv_q[$];
  int          hold_q[$];
  int          req_len_q[$];
  logic        ack_sv_q[$];
  logic [3:0]  exp_q[$];
  int          bank_err = 0;
  int          byte_idx = 0;

  int   seg_ticks = 0;
  bit   seg_open  = 1'b0;
  int   req_run   = 0;
  bit   ack_prev  = 1'b0;
  logic mon_req_d = 1'b0;
  logic mon_busy_d = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    rd_addr_q.delete(); rd_data_q.delete(); sv_q.delete(); hold_q.delete();
    req_len_q.delete(); ack_sv_q.delete(); exp_q.delete();
    bank_err = 0; byte_idx = 0; seg_open = 1'b0; seg_ticks = 0; req_run = 0;
  endtask

  // Tick generator.
  initial begin
    tick = 1'b0;
    forever begin
      @(posedge clk); #1;
      tick = tick_all ? 1'b1 : ($urandom_range(0, 7) != 0);
    end
  end

  // Memory responder: acks a request after a chosen number of cycles and
  // records what it handed out.
  initial begin
    int req_age, cur_delay;
    req_age = 0; cur_delay = 1;
    mem_ack = 1'b0; mem_data = 8'h00;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (mem_req === 1'b1) begin
        if (req_age == 0) cur_delay = $urandom_range(ack_min, ack_max);
        req_age++;
        if (req_age >= cur_delay) begin
          mem_ack  = 1'b1;
          mem_data = data_rand ? 8'($urandom) : 8'(byte_idx);
          rd_addr_q.push_back(mem_addr);
          rd_data_q.push_back(mem_data);
          byte_idx++;
          req_age = 0;
        end
      end else begin
        req_age = 0;
        if (spur_en && $urandom_range(0, 7) == 0) begin
          mem_ack  = 1'b1;
          mem_data = 8'($urandom);
        end
      end
    end
  end

  // Monitor: sample stream, tick count per sample phase, request lengths,
  // response after ack, bank stability.
  always @(negedge clk) begin
    if (sample_valid === 1'b1) begin
      sv_q.push_back(sample);
      if (seg_open) hold_q.push_back(seg_ticks);
      seg_open  = 1'b1;
      seg_ticks = 0;
    end else if (seg_open && ((mem_req && !mon_req_d) || (!busy && mon_busy_d))) begin
      hold_q.push_back(seg_ticks);
      seg_open = 1'b0;
    end
    if (tick) seg_ticks++;
    if (mem_req === 1'b1) req_run++;
    else if (req_run != 0) begin
      req_len_q.push_back(req_run);
      req_run = 0;
    end
    if (ack_prev) ack_sv_q.push_back(sample_valid);
    ack_prev = (mem_req === 1'b1) && (mem_ack === 1'b1);
    if (busy === 1'b1 && mem_bank !== exp_bank) bank_err++;
    mon_req_d  = mem_req;
    mon_busy_d = busy;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic trig(input logic go);
    trigger_data = {go, 7'($urandom)};
    trigger_wr   = 1'b1;
    @(posedge clk); #1;
    trigger_wr   = 1'b0;
    trigger_data = 8'($urandom);
  endtask

  task automatic start_xfer(input logic [15:0] a, input logic [7:0] l, input logic [7:0] c);
    dma_addr = a; dma_length = l; dma_ctrl = c;
    exp_bank = c[6:4];
    trig(1'b1);
  endtask

  task automatic wait_sv(input string tag, input int n, input int budget);
    int seen, k;
    seen = 0; k = 0;
    while (seen < n && k < budget) begin
      @(posedge clk); #1; k++;
      if (sample_valid === 1'b1) seen++;
    end
    chk({tag, " sample pulses"}, seen, n);
  endtask

  task automatic wait_irq(input string tag, input int budget);
    int k;
    k = 0;
    while (irq !== 1'b1 && k < budget) begin @(posedge clk); #1; k++; end
    chk({tag, " irq set"}, irq, 1);
  endtask

  task automatic wait_req_rise(input string tag, input int budget);
    int k;
    k = 0;
    while (mem_req !== 1'b1 && k < budget) begin @(posedge clk); #1; k++; end
    chk({tag, " next fetch"}, mem_req, 1);
  endtask

  // Scoreboard for a completed (or partially observed) transfer of nbytes:
  // consecutive addresses mod 2^16, high nibble then low nibble of each byte,
  // each phase lasting exactly one rate period of ticks.
  task automatic check_xfer(input string tag, input logic [15:0] a, input int nbytes, input int period);
    int n;
    exp_q.delete();
    chk({tag, " reads"}, rd_addr_q.size(), nbytes);
    chk({tag, " samples"}, sv_q.size(), 2 * nbytes);
    chk({tag, " phases"}, hold_q.size(), 2 * nbytes);
    n = nbytes;
    if (rd_addr_q.size() < n) n = rd_addr_q.size();
    if (sv_q.size() < 2 * n) n = sv_q.size() / 2;
    if (hold_q.size() < 2 * n) n = hold_q.size() / 2;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(rd_data_q[i][7:4]);
      exp_q.push_back(rd_data_q[i][3:0]);
      chk($sformatf("%s addr[%0d]", tag, i), rd_addr_q[i], 16'(a + 16'(i)));
    end
    for (int i = 0; i < 2 * n; i++) begin
      chk($sformatf("%s sample[%0d]", tag, i), sv_q[i], exp_q[i]);
      chk($sformatf("%s hold[%0d]", tag, i), hold_q[i], period);
    end
    chk({tag, " bank stable"}, bank_err, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset_n = 1'b0; dma_addr = 16'h0; dma_length = 8'h0; dma_ctrl = 8'h0;
    trigger_wr = 1'b0; trigger_data = 8'h0; irq_ack = 1'b0;

    // Reset state
    wait_cycles(3);
    chk("rst sample", sample, 0);
    chk("rst sample_valid", sample_valid, 0);
    chk("rst busy", busy, 0);
    chk("rst irq", irq, 0);
    chk("rst mem_req", mem_req, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_bank", mem_bank, 0);
    reset_n = 1'b1;
    clear_mon();
    wait_cycles(40);
    chk("post-rst idle busy", busy, 0);
    chk("post-rst idle reads", rd_addr_q.size(), 0);

    // Basic transfer: byte index data, rate 0, random tick gaps
    clear_mon(); data_rand = 1'b0; ack_min = 1; ack_max = 1;
    start_xfer(16'hC000, 8'h01, 8'h00);
    wait_irq("basic", 20000);
    wait_cycles(1);
    check_xfer("basic", 16'hC000, 16, 256);
    chk("basic busy end", busy, 0);
    chk("basic last sample", sample, 4'hF);
    irq_ack = 1'b1; wait_cycles(1); irq_ack = 1'b0;
    chk("basic irq cleared", irq, 0);

    // Address wrap, bank 5, stray acks, register changes mid-transfer,
    // irq_ack coincident with completion (ticks every cycle for exact timing)
    clear_mon(); data_rand = 1'b1; ack_min = 1; ack_max = 3; spur_en = 1'b1; tick_all = 1'b1;
    start_xfer(16'hFFFF, 8'h01, 8'h50);
    dma_addr = 16'h1234; dma_length = 8'h05; dma_ctrl = 8'h23;
    wait_sv("wrap", 32, 20000);
    wait_cycles(255);             // last tick of the final low-nibble period
    irq_ack = 1'b1; wait_cycles(1); irq_ack = 1'b0;
    chk("wrap irq set-wins", irq, 1);
    chk("wrap busy end", busy, 0);
    wait_cycles(1);
    check_xfer("wrap", 16'hFFFF, 16, 256);
    wait_cycles(5);
    irq_ack = 1'b1; wait_cycles(1); irq_ack = 1'b0;
    chk("wrap irq later ack", irq, 0);
    spur_en = 1'b0; tick_all = 1'b0;

    // Abort mid-HI, then restart during LO with rate 3
    clear_mon(); ack_min = 1; ack_max = 2;
    start_xfer(16'h3000, 8'h01, 8'h00);
    wait_sv("abort", 1, 400);
    wait_cycles(50);
    trig(1'b0);
    chk("abort busy", busy, 0);
    chk("abort mem_req", mem_req, 0);
    chk("abort irq", irq, 0);
    chk("abort sample held", sample, (rd_data_q.size() > 0) ? {28'd0, rd_data_q[0][7:4]} : 32'hDEAD);
    wait_cycles(600);
    chk("abort no further samples", sv_q.size(), 1);
    chk("abort still idle", busy, 0);
    chk("abort irq still clear", irq, 0);

    clear_mon();
    start_xfer(16'h3100, 8'h01, 8'h00);
    wait_sv("pre-restart", 2, 2000);
    wait_cycles(20);
    clear_mon();
    start_xfer(16'h5000, 8'h02, 8'h03);
    wait_sv("restart", 2, 8000);
    wait_req_rise("restart", 4000);
    wait_cycles(2);
    chk("restart first addr", (rd_addr_q.size() > 0) ? {16'd0, rd_addr_q[0]} : 32'hDEAD, 16'h5000);
    chk("restart second addr", (rd_addr_q.size() > 1) ? {16'd0, rd_addr_q[1]} : 32'hDEAD, 16'h5001);
    chk("restart hi period", (hold_q.size() > 0) ? hold_q[0] : -1, 2048);
    chk("restart lo period", (hold_q.size() > 1) ? hold_q[1] : -1, 2048);
    chk("restart hi sample", (sv_q.size() > 0 && rd_data_q.size() > 0) ? {28'd0, sv_q[0]} : 32'hDEAD,
        (rd_data_q.size() > 0) ? {28'd0, rd_data_q[0][7:4]} : 32'hBEEF);
    chk("restart bank", bank_err, 0);
    trig(1'b0);
    chk("restart stop busy", busy, 0);

    // Length 0 means 4096 bytes: check the load and the first few bytes
    clear_mon(); ack_min = 1; ack_max = 4;
    start_xfer(16'h4000, 8'h00, 8'h20);
    chk("len0 byte count", dut.cnt_q, 13'h1000);
    wait_sv("len0", 6, 5000);
    wait_req_rise("len0", 1000);
    wait_cycles(6);
    chk("len0 still busy", busy, 1);
    chk("len0 no irq", irq, 0);
    for (int i = 0; i < 4; i++)
      chk($sformatf("len0 addr[%0d]", i), (rd_addr_q.size() > i) ? {16'd0, rd_addr_q[i]} : 32'hDEAD, 32'h4000 + i);
    chk("len0 bank", bank_err, 0);
    trig(1'b0);
    chk("len0 stop busy", busy, 0);

    // Slow memory: 7-cycle ack latency, irq left pending
    clear_mon(); ack_min = 7; ack_max = 7;
    start_xfer(16'h2000, 8'h01, 8'h10);
    wait_irq("slow", 20000);
    wait_cycles(1);
    check_xfer("slow", 16'h2000, 16, 256);
    chk("slow req count", req_len_q.size(), 16);
    chk("slow ack count", ack_sv_q.size(), 16);
    for (int i = 0; i < req_len_q.size() && i < 16; i++)
      chk($sformatf("slow req_len[%0d]", i), req_len_q[i], 7);
    for (int i = 0; i < ack_sv_q.size() && i < 16; i++)
      chk($sformatf("slow sv after ack[%0d]", i), ack_sv_q[i], 1);

    // Reset asserted mid-FETCH
    clear_mon(); ack_min = 50; ack_max = 50;
    start_xfer(16'h6000, 8'h01, 8'h70);
    wait_cycles(3);
    chk("rstmid mem_req before", mem_req, 1);
    reset_n = 1'b0;
    #1;
    chk("rstmid sample", sample, 0);
    chk("rstmid sample_valid", sample_valid, 0);
    chk("rstmid busy", busy, 0);
    chk("rstmid irq", irq, 0);
    chk("rstmid mem_req", mem_req, 0);
    chk("rstmid mem_addr", mem_addr, 0);
    chk("rstmid mem_bank", mem_bank, 0);
    wait_cycles(2);
    reset_n = 1'b1;
    clear_mon(); ack_min = 1; ack_max = 1;
    wait_cycles(300);
    chk("rstmid idle busy", busy, 0);
    chk("rstmid idle reads", rd_addr_q.size(), 0);
    chk("rstmid idle samples", sv_q.size(), 0);
    chk("rstmid idle irq", irq, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/audio_dma_reader.md
AUDIO_DMA_READER -- requirements
Module: audio_dma_reader

Interface
REQ-001 clk  in  1  system clock; all state changes on its rising edge.
REQ-002 reset_n  in  1  reset, asynchronous and active-low.
REQ-003 tick  in  1  CPU-rate enable strobe, one clk wide; all rate timing counts ticks only.
REQ-004 dma_addr  in  16  start byte address, from the audio DMA address low/high registers.
REQ-005 dma_length  in  8  block count; bytes = dma_length*16, with 0 meaning 4096.
REQ-006 dma_ctrl  in  8  [1:0] rate select, [6:4] ROM bank, others ignored.
REQ-007 trigger_wr  in  1  one-clk pulse when the CPU writes the trigger register.
REQ-008 trigger_data  in  8  value written; bit 7 is the start/stop bit.
REQ-009 mem_req  out  1  memory read request.
REQ-010 mem_addr  out  16  read byte address.
REQ-011 mem_bank  out  3  bank for mem_addr 8000-BFFF.
REQ-012 mem_ack  in  1  read complete; mem_data is valid in the same cycle.
REQ-013 mem_data  in  8  read byte.
REQ-014 sample  out  4  current 4-bit PCM sample.
REQ-015 sample_valid  out  1  one-clk pulse each time sample updates.
REQ-016 busy  out  1  high while a transfer is active.
REQ-017 irq  out  1  end-of-transfer interrupt, held until acknowledged.
REQ-018 irq_ack  in  1  one-clk pulse that clears irq.

Function
REQ-019 The block SHALL use the states IDLE, FETCH, HI and LO.
REQ-020 On trigger_wr with trigger_data[7]=1 in any state, the block SHALL latch the following in the next cycle and enter FETCH:
- dma_addr into the address pointer;
- the byte count {dma_length==0, dma_length, 4'b0} into a 13-bit counter;
- dma_ctrl[1:0] and dma_ctrl[6:4].
REQ-021 On trigger_wr with trigger_data[7]=0 while busy, the block SHALL go to IDLE in the next cycle, hold sample, drop mem_req and leave irq unchanged.
REQ-022 In FETCH, mem_req SHALL be 1 and mem_addr SHALL equal the pointer; mem_bank SHALL equal the latched bank at all times.
REQ-023 mem_req SHALL stay high until the cycle in which mem_ack=1; it SHALL be 0 in the cycle after that.
REQ-024 In the FETCH cycle where mem_ack=1, the block SHALL perform all of the following:
- latch mem_data;
- set sample to mem_data[7:4] in the next cycle and pulse sample_valid;
- load the rate counter;
- enter HI.
REQ-025 mem_ack outside FETCH SHALL be ignored.
REQ-026 The rate period SHALL be 256, 512, 1024 or 2048 ticks for a rate select of 0, 1, 2 or 3 respectively.
REQ-027 The rate counter SHALL decrement only on tick and SHALL expire when a tick occurs at count 1.
REQ-028 On expiry in HI, the block SHALL update sample to the latched data[3:0], pulse sample_valid, reload the rate counter and enter LO.
REQ-029 On expiry in LO, the block SHALL decrement the byte counter and increment the pointer modulo 2^16 (FFFF wraps to 0000).
REQ-030 After the LO expiry, if the byte counter has reached 0, the block SHALL enter IDLE and set irq; otherwise it SHALL enter FETCH.
REQ-031 busy SHALL be 1 in FETCH, HI and LO, and 0 in IDLE.
REQ-032 If an irq set and an irq_ack occur in the same cycle, irq SHALL end at 1 (set wins).
REQ-033 A restart trigger in the same cycle as a completion SHALL take priority: irq SHALL still be set and the new transfer SHALL start.
REQ-034 Register inputs SHALL only be sampled at a trigger; changes mid-transfer SHALL have no effect.
REQ-035 sample SHALL hold its last value in IDLE.

Reset
REQ-036 While reset_n=0, the block SHALL hold:
- state IDLE;
- sample=0, sample_valid=0, busy=0, irq=0;
- mem_req=0, mem_addr=0, mem_bank=0;
- all counters at 0.
REQ-037 After reset_n is released, the block SHALL take no action until a trigger.

Verification
REQ-038 Basic transfer:
- stimulus: addr=C000, length=1, ctrl=00, start, mem_data=byte index;
- required: 32 sample_valid pulses;
- required: sample values 0,0,0,1,...,0,F, each held 256 ticks;
- required: irq set after the 16th byte, busy=0.
REQ-039 Length 0:
- stimulus: length=0, rate 0;
- required: 4096 mem_req transactions, then irq.
REQ-040 Address wrap:
- stimulus: addr=FFFF, length=1;
- required: reads FFFF, 0000 through 000E;
- required: mem_bank equals ctrl[6:4]=5 throughout.
REQ-041 Slow memory:
- stimulus: mem_ack delayed 7 cycles;
- required: mem_req stays high for 7 cycles, then low;
- required: sample updates the cycle after ack.
REQ-042 Abort and restart:
- stimulus: stop mid-HI;
- required: IDLE, sample held, no irq;
- stimulus: then start during LO with rate 3;
- required: fresh load and 2048-tick periods.
REQ-043 IRQ handshake:
- stimulus: irq_ack coincident with completion;
- required: irq=1 afterwards;
- stimulus: a later irq_ack;
- required: irq=0.
REQ-044 Reset mid-FETCH:
- stimulus: reset_n=0 while mem_req=1;
- required: all outputs 0 asynchronously;
- required: no activity after release.
